// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and defaults for the truth-table sweeper.
// Imported by the interface, the dwell counter and the top.
package truth_table_sweeper_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int N_IN_DEF   = 4;
   localparam int SETTLE_DEF = 0;
   localparam int TBL_W_DEF  = 2**N_IN_DEF;
   // dwell counter covers SETTLE values 0..15
   localparam int DWELL_W    = 4;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Host/function-side bundle of the truth-table sweeper.
// master = host + function under test, slave = sweeper.
interface truth_table_sweeper_if
   import truth_table_sweeper_pkg::*;
#(
   parameter int N_IN = N_IN_DEF
);

   logic                 start;
   logic                 abort;
   logic [2**N_IN-1:0]   expected;
   logic                 f_in;
   logic [N_IN-1:0]      vec_out;
   logic                 busy;
   logic                 done;
   logic [2**N_IN-1:0]   table_out;
   logic                 mismatch;
   logic [N_IN:0]        mismatch_cnt;
   logic [N_IN-1:0]      first_fail;

   modport master (
      output start, abort, expected, f_in,
      input  vec_out, busy, done, table_out,
      input  mismatch, mismatch_cnt, first_fail
   );

   modport slave (
      input  start, abort, expected, f_in,
      output vec_out, busy, done, table_out,
      output mismatch, mismatch_cnt, first_fail
   );

endinterface

// File: rtl/truth_table_sweeper_dwell_counter.sv
// Loadable down-counter with zero flag; paces the per-vector settle wait.
// Holds at zero until reloaded.
module dwell_counter
   import truth_table_sweeper_pkg::*;
#(
   parameter int W = DWELL_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input vector of a function block, captures its output
// and compares the captured truth table against a reference table.
module truth_table_sweeper
   import truth_table_sweeper_pkg::*;
#(
   parameter int N_IN   = N_IN_DEF,
   parameter int SETTLE = SETTLE_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   truth_table_sweeper_if.slave bus
);

   localparam int              TW    = 2**N_IN;
   localparam logic [N_IN-1:0] LAST  = N_IN'(TW - 1);
   localparam logic [DWELL_W-1:0] SET_V = DWELL_W'(SETTLE);

   state_t          state;
   logic [N_IN-1:0] vec;
   logic            busy_q;
   logic            done_q;
   logic [TW-1:0]   tbl;
   logic            mis;
   logic [N_IN:0]   mis_cnt;
   logic [N_IN-1:0] ffail;

   logic accept;
   logic step;
   logic zero;
   logic f_bad;

   assign accept = (state == IDLE) && bus.start;
   assign step   = (state == RUN) && !bus.abort && zero;
   assign f_bad  = bus.f_in != bus.expected[vec];

   dwell_counter #(.W(DWELL_W)) u_dwell (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept || (step && vec != LAST)),
      .load_val (SET_V),
      .dec      (state == RUN),
      .zero     (zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         vec     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tbl     <= '0;
         mis     <= 1'b0;
         mis_cnt <= '0;
         ffail   <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  vec     <= '0;
                  tbl     <= '0;
                  mis     <= 1'b0;
                  mis_cnt <= '0;
                  ffail   <= '0;
                  busy_q  <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               // abort wins over a sample due on the same edge
               if (bus.abort) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  vec    <= '0;
               end else if (step) begin
                  tbl[vec] <= bus.f_in;
                  if (f_bad) begin
                     mis_cnt <= mis_cnt + (N_IN+1)'(1);
                     mis     <= 1'b1;
                     if (!mis) ffail <= vec;
                  end
                  if (vec == LAST) begin
                     state  <= DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     vec    <= '0;
                  end else begin
                     vec <= vec + N_IN'(1);
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.vec_out      = vec;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.table_out    = tbl;
   assign bus.mismatch     = mis;
   assign bus.mismatch_cnt = mis_cnt;
   assign bus.first_fail   = ffail;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper, SETTLE=0 and SETTLE=3 instances.
// Function under test: f = (a&b)|(c&d), a = vec[3].
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   truth_table_sweeper_if #(.N_IN(4)) b0 ();
   truth_table_sweeper_if #(.N_IN(4)) b3 ();

   truth_table_sweeper #(.N_IN(4), .SETTLE(0)) u0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b0)
   );

   truth_table_sweeper #(.N_IN(4), .SETTLE(3)) u3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b3)
   );

   function automatic logic f_of(logic [3:0] v);
      return (v[3] & v[2]) | (v[1] & v[0]);
   endfunction

   assign b0.f_in = f_of(b0.vec_out);
   assign b3.f_in = f_of(b3.vec_out);

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] outs0();
      return {b0.busy, b0.done, b0.mismatch, b0.mismatch_cnt,
              b0.first_fail, b0.vec_out, b0.table_out};
   endfunction

   function automatic logic [31:0] outs3();
      return {b3.busy, b3.done, b3.mismatch, b3.mismatch_cnt,
              b3.first_fail, b3.vec_out, b3.table_out};
   endfunction

   // full SETTLE=0 sweep; checks latency, busy at done, single pulse
   task automatic sweep0(input string tag, input logic [15:0] exp_tbl);
      int lat;
      b0.expected = exp_tbl;
      b0.start = 1'b1;
      tick;
      b0.start = 1'b0;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         tick;
         if (b0.done === 1'b1) begin
            lat = c;
            break;
         end
      end
      chk({tag, "_lat"}, lat, 16);
      chk({tag, "_busy_at_done"}, 32'(b0.busy), 0);
      chk({tag, "_vec_at_done"}, 32'(b0.vec_out), 0);
      tick;
      chk({tag, "_done_pulse"}, 32'(b0.done), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int serr;
      int lat;
      logic dseen;

      b0.start = 0; b0.abort = 0; b0.expected = '0;
      b3.start = 0; b3.abort = 0; b3.expected = '0;

      // reset
      #12;
      chk("rst_outs0", outs0(), 0);
      chk("rst_outs3", outs3(), 0);
      #10;
      rst_n = 1'b1;
      repeat (5) tick;
      chk("idle_busy_done", {b0.busy, b0.done, b3.busy, b3.done}, 0);

      // happy path and mismatch reporting
      sweep0("happy", 16'hF888);
      chk("happy_tbl", b0.table_out, 16'hF888);
      chk("happy_mis", {b0.mismatch, b0.mismatch_cnt}, 0);

      sweep0("m0", 16'hF889);
      chk("m0_tbl", b0.table_out, 16'hF888);
      chk("m0_mis", 32'(b0.mismatch), 1);
      chk("m0_cnt", 32'(b0.mismatch_cnt), 1);
      chk("m0_ff", 32'(b0.first_fail), 0);

      sweep0("m15", 16'h7888);
      chk("m15_cnt", 32'(b0.mismatch_cnt), 1);
      chk("m15_ff", 32'(b0.first_fail), 15);

      sweep0("mall", 16'h0000);
      chk("mall_mis", 32'(b0.mismatch), 1);
      chk("mall_cnt", 32'(b0.mismatch_cnt), 7);
      chk("mall_ff", 32'(b0.first_fail), 3);

      // results hold while idle
      repeat (4) tick;
      chk("hold_cnt", 32'(b0.mismatch_cnt), 7);

      // settle: each vector held 4 cycles, done 64 cycles after start
      b3.expected = 16'hF888;
      b3.start = 1'b1;
      tick;
      b3.start = 1'b0;
      k = 0;
      serr = 0;
      while (b3.done !== 1'b1 && k < 100) begin
         if (b3.vec_out !== 4'(k / 4)) serr++;
         tick;
         k++;
      end
      chk("settle_stable", serr, 0);
      chk("settle_lat", k, 64);
      chk("settle_tbl", b3.table_out, 16'hF888);
      chk("settle_mis", 32'(b3.mismatch), 0);
      tick;

      // start again at vector 2 is ignored
      b0.expected = 16'hF888;
      b0.start = 1'b1;
      tick;
      b0.start = 1'b0;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         tick;
         if (b0.done === 1'b1) begin
            lat = c;
            break;
         end
         b0.start = (c == 2 && b0.vec_out == 4'd2);
      end
      b0.start = 1'b0;
      chk("restart_lat", lat, 16);
      chk("restart_tbl", b0.table_out, 16'hF888);
      chk("restart_mis", 32'(b0.mismatch), 0);
      tick;

      // abort at vector 5
      b0.start = 1'b1;
      tick;
      b0.start = 1'b0;
      for (int c = 0; c < 20 && b0.vec_out != 4'd5; c++) tick;
      chk("abort_reach5", 32'(b0.vec_out), 5);
      b0.abort = 1'b1;
      tick;
      b0.abort = 1'b0;
      chk("abort_busy", 32'(b0.busy), 0);
      chk("abort_vec", 32'(b0.vec_out), 0);
      chk("abort_tbl", b0.table_out, 16'h0008);
      dseen = b0.done;
      repeat (20) begin
         tick;
         dseen = dseen | b0.done;
      end
      chk("abort_no_done", 32'(dseen), 0);

      // reset mid-sweep at vector 9
      b0.start = 1'b1;
      tick;
      b0.start = 1'b0;
      for (int c = 0; c < 20 && b0.vec_out != 4'd9; c++) tick;
      chk("mrst_reach9", 32'(b0.vec_out), 9);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_outs", outs0(), 0);
      tick;
      rst_n = 1'b1;
      tick;
      sweep0("after_rst", 16'hF888);
      chk("after_rst_tbl", b0.table_out, 16'hF888);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
